dmem_responder: RTL

//  Data-memory responder for the pipelined core's load/store port. Accepts one

---
 rtl/dmem_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store over valid/ready, fixed
// programmable latency, word-addressed 32-bit RAM with byte-enable stores.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    if (LATENCY < 1 || LATENCY > 15) begin : gBadLatency
        $error("dmem_responder: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    typedef struct packed {
        logic              we;
        logic [BYTES-1:0]  be;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
    } reqT;

    logic [DATA_W-1:0] ram [DEPTH];

    stateT             state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    reqT               latReq;
    logic              accept;
    logic              commit;
    logic              addrErr;
    logic [ADDR_W-1:0] idx;

    assign idx     = latReq.addr[ADDR_W+1:2];
    assign addrErr = (latReq.addr[1:0] != 2'b00) | (latReq.addr[31:ADDR_W+2] != '0);

    assign req_ready = (state == IDLE) & rst;

    // Next-state and handshake decode
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    stateNext = WAIT;
                    cntNext   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cntNext = cnt - CNT_W'(1);
                end else begin
                    commit    = 1'b1;
                    stateNext = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Control state, latched request and registered response
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            latReq     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            resp_valid <= (stateNext == RESP);
            if (accept) begin
                latReq <= '{we: req_we, be: req_be, addr: req_addr, wdata: req_wdata};
            end
            if (commit) begin
                resp_err   <= addrErr;
                resp_rdata <= (addrErr || latReq.we) ? '0 : ram[idx];
            end else if (state == RESP && resp_ready) begin
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

    // RAM contents survive reset; a reset edge suppresses a pending commit
    always_ff @(posedge clk) begin
        if (rst && commit && latReq.we && !addrErr) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (latReq.be[b]) begin
                    ram[idx][8*b +: 8] <= latReq.wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
